// File: rtl/sram_burst_client.sv
// Burst initiator for the SRAM arbiter's toggle req/ack port: one command becomes
// sequential single-word accesses, with write words streamed in and read words streamed out.
module sram_burst_client #(
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned READ_LATENCY = 4
) (
  input  logic             clk200,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_read,
  input  logic [18:0]      cmd_address,
  input  logic [LEN_W-1:0] cmd_length,
  input  logic [1:0]       cmd_be,
  input  logic [15:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [15:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             sram_req,
  input  logic             sram_ack,
  output logic             sram_read,
  output logic [18:0]      sram_address,
  output logic             sram_lb,
  output logic             sram_ub,
  output logic [15:0]      sram_out,
  input  logic [15:0]      sram_in
);

  localparam int unsigned      LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DATA, NEXT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               dir_read;
  logic [1:0]         be;
  logic [LEN_W-1:0]   remaining;
  logic [LAT_W-1:0]   lat_cnt;
  logic               link_idle;
  logic               cmd_accept;
  logic               issue_fire;
  logic               last_word;

  // A req/ack mismatch left over from before reset also blocks new commands.
  always_comb begin
    link_idle  = (sram_req == sram_ack);
    cmd_ready  = (state == IDLE) && link_idle;
    wr_ready   = (state == ISSUE) && !dir_read && (remaining != '0);
    cmd_accept = cmd_valid && cmd_ready;
    issue_fire = (state == ISSUE) && (remaining != '0) && (dir_read || wr_valid);
    last_word  = (remaining == LEN_W'(1));
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (cmd_accept) state_nxt = ISSUE;
      ISSUE: begin
        if (remaining == '0)  state_nxt = IDLE;
        else if (issue_fire)  state_nxt = WAIT_ACK;
      end
      WAIT_ACK:  if (link_idle) state_nxt = dir_read ? WAIT_DATA : NEXT;
      WAIT_DATA: if (lat_cnt == '0) state_nxt = NEXT;
      NEXT:      state_nxt = last_word ? IDLE : ISSUE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      dir_read     <= 1'b1;
      be           <= '0;
      remaining    <= '0;
      lat_cnt      <= '0;
      sram_req     <= 1'b0;
      sram_read    <= 1'b1;
      sram_address <= '0;
      sram_lb      <= 1'b0;
      sram_ub      <= 1'b0;
      sram_out     <= '0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_accept) begin
            dir_read     <= cmd_read;
            be           <= cmd_be;
            sram_address <= cmd_address;
            remaining    <= cmd_length;
            busy         <= 1'b1;
            // Zero-length bursts complete without touching the SRAM.
            done         <= (cmd_length == '0);
          end
        end
        ISSUE: begin
          if (remaining == '0) begin
            busy <= 1'b0;
          end else if (issue_fire) begin
            sram_read <= dir_read;
            sram_lb   <= be[0];
            sram_ub   <= be[1];
            sram_req  <= ~sram_req;
            if (!dir_read) sram_out <= wr_data;
          end
        end
        WAIT_ACK: begin
          if (link_idle) lat_cnt <= LAT_INIT;
        end
        WAIT_DATA: begin
          if (lat_cnt == '0) rd_data <= sram_in;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        NEXT: begin
          remaining    <= remaining - 1'b1;
          sram_address <= sram_address + 19'd1;
          rd_valid     <= dir_read;
          if (last_word) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_burst_client.sv
// Directed bench for sram_burst_client with a toggle-handshake arbiter model
// that answers each access after a programmable delay and drives read data in a one-cycle window.
module tb_sram_burst_client;

  localparam int unsigned LEN_W        = 8;
  localparam int unsigned READ_LATENCY = 4;

  logic             clk200 = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_read = 1'b0;
  logic [18:0]      cmd_address = '0;
  logic [LEN_W-1:0] cmd_length = '0;
  logic [1:0]       cmd_be = '0;
  logic [15:0]      wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [15:0]      rd_data;
  logic             rd_valid;
  logic             busy;
  logic             done;
  logic             sram_req;
  logic             sram_ack = 1'b1;
  logic             sram_read;
  logic [18:0]      sram_address;
  logic             sram_lb;
  logic             sram_ub;
  logic [15:0]      sram_out;
  logic [15:0]      sram_in = 16'hDEAD;

  sram_burst_client #(.LEN_W(LEN_W), .READ_LATENCY(READ_LATENCY)) dut (
    .clk200(clk200), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
    .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_be(cmd_be),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .sram_req(sram_req), .sram_ack(sram_ack), .sram_read(sram_read),
    .sram_address(sram_address), .sram_lb(sram_lb), .sram_ub(sram_ub),
    .sram_out(sram_out), .sram_in(sram_in)
  );

  always #5 clk200 = ~clk200;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Arbiter model
  int          cyc = 0;
  bit          arb_en = 1'b0;
  int          ack_delay = 2;
  bit          m_busy = 1'b0;
  int          req_cyc = 0;
  bit          rd_win = 1'b0;
  int          rd_at = 0;
  logic [15:0] rd_word = '0;
  logic [15:0] rd_q[$];
  int          n_acc = 0;
  int          n_ack = 0;
  logic [18:0] acc_addr[64];
  logic        acc_read[64];
  logic [1:0]  acc_be[64];
  logic [15:0] acc_out[64];
  int          acc_ack[64];

  always begin
    @(posedge clk200);
    #1;
    cyc++;
    if (rd_win && cyc == rd_at) begin
      sram_in = rd_word;
    end else if (rd_win && cyc == rd_at + 1) begin
      sram_in = 16'hDEAD;
      rd_win  = 1'b0;
    end
    if (m_busy && cyc == req_cyc + ack_delay) begin
      check("stable_ctl", {10'b0, sram_read, sram_ub, sram_lb, sram_address},
            {10'b0, acc_read[n_acc-1], acc_be[n_acc-1], acc_addr[n_acc-1]});
      check("stable_out", 32'(sram_out), 32'(acc_out[n_acc-1]));
      sram_ack = ~sram_ack;
      acc_ack[n_acc-1] = cyc;
      n_ack++;
      if (acc_read[n_acc-1]) begin
        rd_win  = 1'b1;
        rd_at   = cyc + 4;
        rd_word = (rd_q.size() > 0) ? rd_q.pop_front() : 16'hDEAD;
      end
      m_busy = 1'b0;
    end else if (!m_busy && arb_en && sram_req != sram_ack && n_acc < 64) begin
      acc_addr[n_acc] = sram_address;
      acc_read[n_acc] = sram_read;
      acc_be[n_acc]   = {sram_ub, sram_lb};
      acc_out[n_acc]  = sram_out;
      n_acc++;
      m_busy  = 1'b1;
      req_cyc = cyc;
    end
  end

  // Output monitor
  int          n_rd = 0;
  logic [15:0] rd_val[64];
  int          rd_cyc[64];
  int          n_done = 0;
  int          done_cyc = 0;
  int          n_tog = 0;
  logic        prev_req = 1'b0;

  always @(negedge clk200) begin
    if (rd_valid && n_rd < 64) begin
      rd_val[n_rd] = rd_data;
      rd_cyc[n_rd] = cyc;
      n_rd++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (sram_req !== prev_req) begin
      if (!rst) n_tog++;
      prev_req = sram_req;
    end
  end

  task automatic tick();
    @(negedge clk200);
    #1;
  endtask

  task automatic send_cmd(input logic rd, input logic [18:0] a, input logic [LEN_W-1:0] len,
                          input logic [1:0] be, output int edge_no);
    @(posedge clk200);
    #2;
    cmd_read = rd; cmd_address = a; cmd_length = len; cmd_be = be; cmd_valid = 1'b1;
    edge_no = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cmd_ready) break;
    end
    if (!cmd_ready) begin
      check("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk200);
      #2;
      edge_no   = cyc;
      cmd_valid = 1'b0;
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    @(posedge clk200);
    #2;
    wr_data = d; wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (wr_ready) break;
    end
    if (!wr_ready) check("wr_ready_timeout", 32'(wr_ready), 32'd1);
    @(posedge clk200);
    #2;
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int prev);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_done != prev) break;
    end
    check(tag, n_done - prev, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, tog0, d0, r0, e, t, cnt;

    // T1: arbiter ack left at 1 across reset
    repeat (3) @(posedge clk200);
    #2 rst = 1'b0;
    tick();
    check("t1_req",      32'(sram_req),     32'd0);
    check("t1_read",     32'(sram_read),    32'd1);
    check("t1_addr",     32'(sram_address), 32'd0);
    check("t1_be",       32'({sram_ub, sram_lb}), 32'd0);
    check("t1_out",      32'(sram_out),     32'd0);
    check("t1_rd_data",  32'(rd_data),      32'd0);
    check("t1_flags",    32'({rd_valid, busy, done, wr_ready}), 32'd0);
    check("t1_cmd_rdy0", 32'(cmd_ready),    32'd0);
    repeat (3) tick();
    check("t1_cmd_rdy_hold", 32'(cmd_ready), 32'd0);
    arb_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_ready) break;
    end
    check("t1_cmd_rdy1",    32'(cmd_ready), 32'd1);
    check("t1_resync_read", 32'(acc_read[0]), 32'd1);

    // T2: write burst of three words
    base = n_acc; tog0 = n_tog; d0 = n_done;
    send_cmd(1'b0, 19'h00010, 8'd3, 2'b11, e);
    push_word(16'h1111);
    push_word(16'h2222);
    push_word(16'h3333);
    wait_done("t2_done", d0);
    check("t2_acc_cnt", n_acc - base, 3);
    for (int i = 0; i < 3; i++) begin
      check("t2_addr", 32'(acc_addr[base+i]), 32'h10 + 32'(i));
      check("t2_dir",  32'(acc_read[base+i]), 32'd0);
      check("t2_be",   32'(acc_be[base+i]),   32'd3);
    end
    check("t2_out0", 32'(acc_out[base]),   32'h1111);
    check("t2_out1", 32'(acc_out[base+1]), 32'h2222);
    check("t2_out2", 32'(acc_out[base+2]), 32'h3333);
    check("t2_toggles", n_tog - tog0, 3);
    check("t2_done_cyc", done_cyc, acc_ack[base+2] + 2);
    check("t2_busy_off", 32'(busy), 32'd0);
    repeat (3) tick();
    check("t2_single_done", n_done - d0, 1);

    // T3: read burst wrapping the top address
    base = n_acc; d0 = n_done; r0 = n_rd;
    rd_q.push_back(16'hA5A5);
    rd_q.push_back(16'h5A5A);
    send_cmd(1'b1, 19'h7FFFF, 8'd2, 2'b01, e);
    wait_done("t3_done", d0);
    check("t3_acc_cnt", n_acc - base, 2);
    check("t3_addr0", 32'(acc_addr[base]),   32'h7FFFF);
    check("t3_addr1", 32'(acc_addr[base+1]), 32'h00000);
    check("t3_dir",   32'({acc_read[base], acc_read[base+1]}), 32'd3);
    check("t3_be",    32'(acc_be[base]), 32'd1);
    check("t3_rd_cnt", n_rd - r0, 2);
    check("t3_rd0", 32'(rd_val[r0]),   32'hA5A5);
    check("t3_rd1", 32'(rd_val[r0+1]), 32'h5A5A);
    check("t3_rd0_cyc", rd_cyc[r0],   acc_ack[base] + 6);
    check("t3_rd1_cyc", rd_cyc[r0+1], acc_ack[base+1] + 6);
    check("t3_done_cyc", done_cyc, rd_cyc[r0+1]);

    // T4: write word withheld for ten cycles
    base = n_acc; tog0 = n_tog; d0 = n_done; cnt = 0;
    send_cmd(1'b0, 19'h00200, 8'd1, 2'b10, e);
    repeat (10) begin
      tick();
      if (wr_ready) cnt++;
    end
    check("t4_wr_ready_held", cnt, 10);
    check("t4_no_toggle", n_tog - tog0, 0);
    push_word(16'hBEEF);
    wait_done("t4_done", d0);
    check("t4_acc_cnt", n_acc - base, 1);
    check("t4_addr", 32'(acc_addr[base]), 32'h200);
    check("t4_out",  32'(acc_out[base]),  32'hBEEF);
    check("t4_be",   32'(acc_be[base]),   32'd2);
    check("t4_toggles", n_tog - tog0, 1);

    // T5: zero-length command
    tog0 = n_tog; d0 = n_done;
    send_cmd(1'b0, 19'h00300, 8'd0, 2'b11, e);
    tick();
    check("t5_done_busy", 32'({done, busy}), 32'd3);
    tick();
    check("t5_idle", 32'({done, busy, cmd_ready}), 32'd1);
    check("t5_no_toggle", n_tog - tog0, 0);
    check("t5_done_cnt", n_done - d0, 1);

    // T6: reset during the read-latency wait
    base = n_acc; d0 = n_done; r0 = n_rd;
    rd_q.delete();
    rd_q.push_back(16'h0001);
    send_cmd(1'b1, 19'h00400, 8'd4, 2'b11, e);
    for (int i = 0; i < 50; i++) begin
      tick();
      if (n_ack > base) break;
    end
    check("t6_first_ack", n_ack - base, 1);
    t = acc_ack[base];
    for (int i = 0; i < 20; i++) begin
      @(posedge clk200);
      #2;
      if (cyc >= t + 3) break;
    end
    ack_delay = 4;
    rst = 1'b1;
    tick();
    check("t6_rst_req",  32'(sram_req),     32'd0);
    check("t6_rst_read", 32'(sram_read),    32'd1);
    check("t6_rst_addr", 32'(sram_address), 32'd0);
    check("t6_rst_misc", 32'({sram_ub, sram_lb, rd_valid, busy, done, wr_ready}), 32'd0);
    check("t6_rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk200);
    #2;
    @(posedge clk200);
    #2 rst = 1'b0;
    tick();
    check("t6_cmd_rdy_blocked", 32'(cmd_ready), 32'd0);
    send_cmd(1'b1, 19'h00500, 8'd2, 2'b11, e);
    ack_delay = 2;
    rd_q.delete();
    rd_q.push_back(16'h1234);
    rd_q.push_back(16'h5678);
    check("t6_no_rd_valid", n_rd - r0, 0);
    check("t6_no_done", n_done - d0, 0);
    check("t6_ghost_read", 32'(acc_read[base+1]), 32'd1);
    check("t6_accept_after_ack", 32'(e > acc_ack[base+1]), 32'd1);
    wait_done("t6_done", d0);
    check("t6_acc_cnt", n_acc - base, 4);
    check("t6_addr0", 32'(acc_addr[base+2]), 32'h500);
    check("t6_addr1", 32'(acc_addr[base+3]), 32'h501);
    check("t6_rd_cnt", n_rd - r0, 2);
    check("t6_rd0", 32'(rd_val[r0]),   32'h1234);
    check("t6_rd1", 32'(rd_val[r0+1]), 32'h5678);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
